// File: rtl/sha3_scanner_pkg.sv
// Shared constants and FSM encoding for the SHA3 scan scheduler and its scanner.
// Word counts describe the job block and hash state exchanged with the scanner.
package sha3_scanner_pkg;

  localparam int unsigned BlobWords   = 24;
  localparam int unsigned HashWords   = 50;
  localparam int unsigned NonceIdx    = 21;
  localparam int unsigned BusyTimeout = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StReport
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last advanced grant.
// Grant is combinational; the pointer moves only on an advance strobe with a live request.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_advance,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDW-1:0]   o_grant_idx
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_idx;
  logic           w_hit;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_idx       = '0;
    w_hit       = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = IDW'((32'(r_ptr) + k) % N_REQ);
      if (!w_hit && i_req[w_idx]) begin
        w_hit          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_hit) begin
      r_ptr <= (o_grant_idx == IDW'(N_REQ - 1)) ? '0 : o_grant_idx + IDW'(1);
    end
  end

endmodule

// File: rtl/sha3_scan_scheduler.sv
// Hands requester jobs one at a time to a single SHA3 nonce scanner and reports
// the outcome back with the owning requester id.
module sha3_scan_scheduler
  import sha3_scanner_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_valid,
  output logic [N_REQ-1:0]                     req_ready,
  input  logic [N_REQ-1:0][BlobWords-1:0][31:0] req_blobby,
  input  logic [N_REQ-1:0][63:0]               req_threshold,
  output logic                                 scn_start,
  output logic [BlobWords-1:0][31:0]           scn_blobby,
  output logic [63:0]                          scn_threshold,
  input  logic                                 scn_ready,
  input  logic                                 scn_found,
  input  logic [31:0]                          scn_nonce,
  input  logic [HashWords-1:0][31:0]           scn_hash,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [IDW-1:0]                       res_id,
  output logic                                 res_found,
  output logic [31:0]                          res_nonce,
  output logic [HashWords-1:0][31:0]           res_hash
);

  localparam logic [3:0] BusyLast = 4'(BusyTimeout - 1);

  sched_state_e               r_state;
  sched_state_e               w_state_d;
  logic [N_REQ-1:0]           w_grant;
  logic [IDW-1:0]             w_grant_idx;
  logic                       w_accept;
  logic [3:0]                 r_busy_cnt;
  logic [BlobWords-1:0][31:0] r_blobby;
  logic [63:0]                r_threshold;
  logic [IDW-1:0]             r_id;
  logic                       r_found;
  logic [31:0]                r_nonce;
  logic [HashWords-1:0][31:0] r_hash;

  assign w_accept = (r_state == StIdle) && (|req_valid) && !rst;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req_valid),
    .i_advance  (w_accept),
    .o_grant    (w_grant),
    .o_grant_idx(w_grant_idx)
  );

  always_comb begin
    w_state_d = r_state;
    req_ready = '0;
    scn_start = 1'b0;
    res_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|req_valid) begin
          req_ready = w_grant;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        scn_start = 1'b1;
        if (scn_ready) w_state_d = StWaitBusy;
      end
      StWaitBusy: begin
        // A scanner that never drops ready missed the strobe; issue it again.
        if (!scn_ready) w_state_d = StWaitDone;
        else if (r_busy_cnt == BusyLast) w_state_d = StIssue;
      end
      StWaitDone: begin
        if (scn_ready) w_state_d = StReport;
      end
      StReport: begin
        res_valid = 1'b1;
        if (res_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (rst) begin
      req_ready = '0;
      scn_start = 1'b0;
      res_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_busy_cnt  <= '0;
      r_blobby    <= '0;
      r_threshold <= '0;
      r_id        <= '0;
      r_found     <= 1'b0;
      r_nonce     <= '0;
      r_hash      <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_blobby    <= req_blobby[w_grant_idx];
        r_threshold <= req_threshold[w_grant_idx];
        r_id        <= w_grant_idx;
      end
      if (r_state == StWaitBusy) r_busy_cnt <= r_busy_cnt + 4'd1;
      else r_busy_cnt <= '0;
      // Scanner reports an offset; an exhausted range reports nothing.
      if ((r_state == StWaitDone) && scn_ready) begin
        r_found <= scn_found;
        r_nonce <= scn_found ? r_blobby[NonceIdx] + scn_nonce : '0;
        r_hash  <= scn_found ? scn_hash : '0;
      end
    end
  end

  assign scn_blobby    = r_blobby;
  assign scn_threshold = r_threshold;
  assign res_id        = r_id;
  assign res_found     = r_found;
  assign res_nonce     = r_nonce;
  assign res_hash      = r_hash;

endmodule

// File: doc/sha3_scan_scheduler.md
SHA3_SCAN_SCHEDULER -- requirements
Module: sha3_scan_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of job requesters (2..16).
REQ-002 SHALL have parameter IDW, default $clog2(N_REQ), giving the requester-id width.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  N_REQ  per-requester job offer.
REQ-006 SHALL have port req_ready  out  N_REQ  one-hot accept pulse.
REQ-007 SHALL have port req_blobby  in  N_REQ x 24 x 32  job block; word 21 carries the start nonce.
REQ-008 SHALL have port req_threshold  in  N_REQ x 64  per-job difficulty.
REQ-009 SHALL have port scn_start  out  1  start strobe to the scanner.
REQ-010 SHALL have port scn_blobby  out  24 x 32  latched job block.
REQ-011 SHALL have port scn_threshold  out  64  latched threshold.
REQ-012 SHALL have port scn_ready  in  1  scanner idle/pipeline drained.
REQ-013 SHALL have port scn_found  in  1  scanner hit flag.
REQ-014 SHALL have port scn_nonce  in  32  scanner hit offset, relative to the start nonce.
REQ-015 SHALL have port scn_hash  in  50 x 32  scanner hit state.
REQ-016 SHALL have port res_valid  out  1  result available.
REQ-017 SHALL have port res_ready  in  1  result consumer accept.
REQ-018 SHALL have port res_id  out  IDW  requester that owns the result.
REQ-019 SHALL have port res_found  out  1  a hash below threshold was found.
REQ-020 SHALL have port res_nonce  out  32  absolute winning nonce.
REQ-021 SHALL have port res_hash  out  50 x 32  winning hash.

Function
REQ-022 SHALL implement the FSM IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> REPORT -> IDLE.
REQ-023 IDLE: when any req_valid is set, SHALL grant round-robin starting from the index after the last grant (index 0 after reset), pulse req_ready[grant] for exactly 1 cycle, latch blobby, threshold and id, then go to ISSUE.
REQ-024 ISSUE: SHALL hold scn_start high until a cycle where scn_ready is high, then go to WAIT_BUSY; scn_start SHALL be low in every other state.
REQ-025 WAIT_BUSY: SHALL wait for scn_ready low, which the scanner drops 2 cycles after capture, then go to WAIT_DONE.
REQ-026 WAIT_DONE: on scn_ready high, SHALL latch scn_found and scn_hash, compute res_nonce = req_blobby[21] + scn_nonce modulo 2^32, then go to REPORT.
REQ-027 REPORT: SHALL assert res_valid with stable res_* values until res_ready is sampled high, then go to IDLE; res_valid SHALL fall on the next cycle.
REQ-028 When res_found is 0 (32-bit range exhausted), res_nonce and res_hash SHALL be 0.
REQ-029 scn_blobby and scn_threshold SHALL stay constant from the accept cycle until the next accept.
REQ-030 A requester deasserting req_valid before a grant SHALL NOT be granted; a requester whose valid stays high SHALL be granted within N_REQ jobs.
REQ-031 At most one job SHALL be in flight; no req_ready SHALL pulse outside IDLE.
REQ-032 If WAIT_BUSY does not see scn_ready low within 8 cycles, SHALL return to ISSUE and re-strobe the scanner.
REQ-033 The nonce sum SHALL wrap, e.g. 0xFFFFFFFE + 3 = 0x00000001.

Reset
REQ-034 On rst: state SHALL be IDLE, the round-robin pointer 0, and req_ready, scn_start, res_valid, res_found, res_id, res_nonce, res_hash all 0.
REQ-035 rst asserted mid-job SHALL abandon the job without reporting; the scanner is reset from the same rst.

Structure
REQ-036 The FSM state enum, the blobby word count (24), the hash word count (50) and the nonce word index (21) SHALL live in a shared package, sha3_scanner_pkg.
REQ-037 The round-robin grant SHALL be a sub-module, rr_arbiter (request vector, advance strobe, one-hot grant, encoded index).

Verification
REQ-038 Scenario: single job on requester 2, start nonce 0x10, scanner hit at offset 5 -> res_id=2, res_found=1, res_nonce=0x15, exactly one req_ready pulse.
REQ-039 Scenario: all 4 requesters valid continuously -> grants in order 0,1,2,3,0; one scn_start sequence per job.
REQ-040 Scenario: res_ready held low for 20 cycles -> res_* stable throughout, and no new grant until accepted.
REQ-041 Scenario: start nonce 0xFFFFFFF0, hit offset 0x20 -> res_nonce=0x00000010.
REQ-042 Scenario: scanner exhausts the range without a hit -> res_found=0, res_nonce=0, res_hash=0.
REQ-043 Scenario: rst during WAIT_DONE -> res_valid never asserts; the next job is granted starting from requester 0.
